// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite signal bundle shared by one initiator and one target.
// The master view drives address/data/valid; the slave view drives readies and responses.
interface axil_interface #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one registered response out.
// Zero-wait slave gives rsp_valid 3 cycles after acceptance; cmd_ready only in IDLE.
module axil_cmd_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_wstrb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic [1:0]      rsp_resp,
  output logic            rsp_timeout,
  output logic            busy,
  axil_interface.master   m_axil
);

  localparam int         CW          = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0] AXIL_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WRITE, RDADDR, RDDATA, RESP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done;
  logic            tmo_hit;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    done          = 1'b0;
    tmo_hit       = 1'b0;

    // Timeout fires in the cycle whose incremented count reaches TIMEOUT.
    if (TIMEOUT > 0 && (state_q == WRITE || state_q == RDADDR || state_q == RDDATA)) begin
      cnt_d   = cnt_q + CW'(1);
      tmo_hit = (cnt_d == CW'(TIMEOUT));
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cnt_d  = '0;
          addr_d = cmd_addr;
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RDADDR;
          end
        end
      end
      WRITE: begin
        if (awvalid_q && m_axil.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil.wready)   wvalid_d  = 1'b0;
        if (bready_q && m_axil.bvalid) begin
          done        = 1'b1;
          rsp_resp_d  = m_axil.bresp;
          rsp_rdata_d = '0;
        end
      end
      RDADDR: begin
        if (arvalid_q && m_axil.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDDATA;
        end
      end
      RDDATA: begin
        if (rready_q && m_axil.rvalid) begin
          done        = 1'b1;
          rsp_resp_d  = m_axil.rresp;
          rsp_rdata_d = m_axil.rdata;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A completing B/R beat takes priority over a simultaneous timeout.
    if (done || tmo_hit) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_timeout_d = !done;
      state_d       = RESP;
      if (!done) begin
        rsp_resp_d  = AXIL_SLVERR;
        rsp_rdata_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

  assign m_axil.awaddr  = addr_q;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Randomised bench for axil_cmd_master: scripted AXI-Lite slave, per-transaction
// expected response from a latency/outcome model, checked by an independent monitor.
module tb_axil_cmd_master;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic          busy;

  axil_interface #(.AW(AW), .DW(DW)) axil ();

  axil_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .m_axil(axil.master)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          a_at;   // cycle (from acceptance) the slave raises awready/arready
    int          w_at;   // cycle the slave raises wready
    int          lat;    // extra cycles before bvalid/rvalid after address/data beats
    bit          hang;   // slave never returns B/R
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          stall;  // cycles rsp_ready is held low once rsp_valid appears
  } txn_t;

  typedef struct {
    int          rise;
    logic [31:0] rdata;
    logic [1:0]  resp;
    bit          tmo;
    int          stall;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Outcome model: the B/R beat lands one cycle after the later address/data beat
  // plus slave latency; it counts only if it lands no later than cycle TMO.
  function automatic exp_t model(input txn_t t, input int acc);
    exp_t e;
    int   beat;
    int   last;
    last = t.wr ? ((t.a_at > t.w_at) ? t.a_at : t.w_at) : t.a_at;
    beat = last + 1 + t.lat;
    e.stall = t.stall;
    if (!t.hang && beat <= TMO) begin
      e.rise  = acc + beat + 1;
      e.rdata = t.wr ? 32'h0 : t.rdata;
      e.resp  = t.resp;
      e.tmo   = 1'b0;
    end else begin
      e.rise  = acc + TMO + 1;
      e.rdata = 32'h0;
      e.resp  = 2'b10;
      e.tmo   = 1'b1;
    end
    return e;
  endfunction

  function automatic txn_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input int a_at, input int w_at, input int lat, input bit hang,
                              input logic [1:0] resp, input int stall);
    txn_t t;
    t.wr = wr; t.addr = addr; t.data = data; t.strb = 4'hF;
    t.a_at = a_at; t.w_at = w_at; t.lat = lat; t.hang = hang;
    t.resp = resp; t.rdata = data; t.stall = stall;
    return t;
  endfunction

  task automatic slave_idle();
    axil.awready = 1'b0; axil.wready = 1'b0; axil.bvalid = 1'b0; axil.bresp = 2'b00;
    axil.arready = 1'b0; axil.rvalid = 1'b0; axil.rdata = '0;   axil.rresp = 2'b00;
  endtask

  task automatic do_txn(input txn_t t);
    bit a_done, w_done, fin;
    int a_hs, w_hs, n, last;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = t.wr; cmd_addr = t.addr;
    cmd_wdata = t.data; cmd_wstrb = t.strb;
    exp_q.push_back(model(t, cyc));
    a_done = 1'b0; w_done = !t.wr; a_hs = 0; w_hs = 0; fin = 1'b0;
    for (int c = 1; c <= 60 && !fin; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (!busy) begin
        fin = 1'b1;
      end else if (t.wr) begin
        chk("awvalid", 64'(axil.awvalid), 64'(!a_done && c <= TMO));
        chk("wvalid",  64'(axil.wvalid),  64'(!w_done && c <= TMO));
        if (axil.awvalid) begin
          chk("awaddr", 64'(axil.awaddr), 64'(t.addr));
          chk("awprot", 64'(axil.awprot), 64'(0));
        end
        if (axil.wvalid) begin
          chk("wdata", 64'(axil.wdata), 64'(t.data));
          chk("wstrb", 64'(axil.wstrb), 64'(t.strb));
        end
        last = (a_hs > w_hs) ? a_hs : w_hs;
        axil.awready = !a_done && c >= t.a_at;
        axil.wready  = !w_done && c >= t.w_at;
        axil.bvalid  = a_done && w_done && !t.hang && c >= last + 1 + t.lat;
        axil.bresp   = axil.bvalid ? t.resp : 2'b00;
        if (axil.awvalid && axil.awready) begin a_done = 1'b1; a_hs = c; end
        if (axil.wvalid && axil.wready)   begin w_done = 1'b1; w_hs = c; end
      end else begin
        chk("arvalid", 64'(axil.arvalid), 64'(!a_done && c <= TMO));
        if (axil.arvalid) begin
          chk("araddr", 64'(axil.araddr), 64'(t.addr));
          chk("arprot", 64'(axil.arprot), 64'(0));
        end
        axil.arready = !a_done && c >= t.a_at;
        axil.rvalid  = a_done && !t.hang && c >= a_hs + 1 + t.lat;
        axil.rdata   = axil.rvalid ? t.rdata : 32'h0;
        axil.rresp   = axil.rvalid ? t.resp : 2'b00;
        if (axil.arvalid && axil.arready) begin a_done = 1'b1; a_hs = c; end
      end
    end
    if (!fin) chk("txn_complete_busy", 64'(busy), 64'(0));
    slave_idle();
  endtask

  // Response sink + scoreboard monitor.
  initial begin : monitor
    bit   in_rsp;
    int   stall_left;
    exp_t e;
    in_rsp = 1'b0;
    stall_left = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        in_rsp = 1'b0;
        rsp_ready = 1'b1;
      end else if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
          rsp_ready = 1'b1;
        end else begin
          e = exp_q[0];
          if (!in_rsp) begin
            chk("rsp_latency", 64'(cyc), 64'(e.rise));
            stall_left = e.stall;
            in_rsp = 1'b1;
          end
          chk("rsp_rdata",   64'(rsp_rdata),   64'(e.rdata));
          chk("rsp_resp",    64'(rsp_resp),    64'(e.resp));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
          if (stall_left > 0) begin
            rsp_ready = 1'b0;
            stall_left--;
          end else begin
            rsp_ready = 1'b1;
            void'(exp_q.pop_front());
            in_rsp = 1'b0;
          end
        end
      end else begin
        rsp_ready = 1'b1;
        if (exp_q.size() > 0 && !in_rsp && cyc > exp_q[0].rise) begin
          chk("rsp_missing", 64'(rsp_valid), 64'(1));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : stim
    txn_t t;
    int   n;
    slave_idle();
    #2;
    chk("rst_cmd_ready",   64'(cmd_ready),    64'(1));
    chk("rst_busy",        64'(busy),         64'(0));
    chk("rst_awvalid",     64'(axil.awvalid), 64'(0));
    chk("rst_wvalid",      64'(axil.wvalid),  64'(0));
    chk("rst_bready",      64'(axil.bready),  64'(0));
    chk("rst_arvalid",     64'(axil.arvalid), 64'(0));
    chk("rst_rready",      64'(axil.rready),  64'(0));
    chk("rst_rsp_valid",   64'(rsp_valid),    64'(0));
    chk("rst_rsp_resp",    64'(rsp_resp),     64'(0));
    chk("rst_rsp_rdata",   64'(rsp_rdata),    64'(0));
    chk("rst_rsp_timeout", 64'(rsp_timeout),  64'(0));
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    do_txn(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 1, 0, 1'b0, 2'b00, 0));
    do_txn(mk(1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4, 1, 0, 1'b0, 2'b10, 1));
    do_txn(mk(1'b0, 32'h0000_0020, 32'h1234_5678, 3, 0, 0, 1'b0, 2'b00, 5));
    do_txn(mk(1'b0, 32'h0000_0024, 32'h0,        99, 0, 0, 1'b1, 2'b00, 0));
    do_txn(mk(1'b1, 32'h0000_0028, 32'h5555_AAAA, 1, 1, 6, 1'b0, 2'b01, 0));
    do_txn(mk(1'b1, 32'h0000_002C, 32'h0BAD_0BAD, 1, 1, 7, 1'b0, 2'b00, 2));

    // Asynchronous reset while a write is waiting on awready.
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h77; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_awvalid", 64'(axil.awvalid), 64'(1));
    rstn = 1'b0;
    #1;
    chk("mid_rst_awvalid",   64'(axil.awvalid), 64'(0));
    chk("mid_rst_wvalid",    64'(axil.wvalid),  64'(0));
    chk("mid_rst_bready",    64'(axil.bready),  64'(0));
    chk("mid_rst_cmd_ready", 64'(cmd_ready),    64'(1));
    chk("mid_rst_busy",      64'(busy),         64'(0));
    chk("mid_rst_rsp_valid", 64'(rsp_valid),    64'(0));
    @(negedge clk);
    rstn = 1'b1;
    do_txn(mk(1'b0, 32'h0000_0044, 32'h8765_4321, 1, 0, 1, 1'b0, 2'b00, 0));

    for (int i = 0; i < 40; i++) begin
      t.wr    = 1'($urandom_range(0, 1));
      t.addr  = $urandom & 32'hFFFF_FFFC;
      t.data  = $urandom;
      t.strb  = 4'($urandom_range(0, 15));
      t.a_at  = int'($urandom_range(1, 6));
      t.w_at  = int'($urandom_range(1, 6));
      t.lat   = int'($urandom_range(0, 4));
      t.hang  = ($urandom_range(0, 7) == 0);
      t.resp  = 2'($urandom_range(0, 3));
      t.rdata = $urandom;
      t.stall = int'($urandom_range(0, 3));
      do_txn(t);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
